// File: rtl/sprite_compositor.sv
// Sprite compositor: latches the game-logic sprite state once per frame into
// shadow registers, resolves per-pixel sprite hits by priority and emits a
// 12-bit RGB colour through a fixed two-stage pipeline.
// Optional build macro: DEATH_FLASH_EN enables the post-death pacman flash.
module sprite_compositor #(
  parameter int unsigned SPRITE_SIZE  = 16,
  parameter int unsigned DEATH_FRAMES = 120,
  parameter int unsigned FLASH_PERIOD = 8,
  parameter logic [11:0] BG_COLOR     = 12'h000,
  parameter logic [11:0] PACMAN_COLOR = 12'hFF0,
  parameter logic [11:0] BLINKY_COLOR = 12'hF00,
  parameter logic [11:0] PINKY_COLOR  = 12'hF8C,
  parameter logic [11:0] INKY_COLOR   = 12'h0FF,
  parameter logic [11:0] CLYDE_COLOR  = 12'hF80
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic [10:0] pacman_pos_x,
  input  logic [9:0]  pacman_pos_y,
  input  logic [10:0] blinky_pos_x,
  input  logic [9:0]  blinky_pos_y,
  input  logic [10:0] pinky_pos_x,
  input  logic [9:0]  pinky_pos_y,
  input  logic [10:0] inky_pos_x,
  input  logic [9:0]  inky_pos_y,
  input  logic [10:0] clyde_pos_x,
  input  logic [9:0]  clyde_pos_y,
  input  logic [3:0]  pacman_moving_dir,
  input  logic        pacman_is_dead,
  output logic [11:0] rgb,
  output logic        rgb_valid
);

  // Sprite slot indices inside the packed position arrays.
  localparam int unsigned IdxPac    = 0;
  localparam int unsigned IdxBlinky = 1;
  localparam int unsigned IdxPinky  = 2;
  localparam int unsigned IdxInky   = 3;
  localparam int unsigned IdxClyde  = 4;

  // Extents computed one bit wider than the coordinates so that sprites near
  // the right/bottom edge do not wrap around to column/row zero.
  localparam logic [11:0] SizeX = 12'(SPRITE_SIZE);
  localparam logic [10:0] SizeY = 11'(SPRITE_SIZE);

  // Mouth notch bounds in local sprite coordinates.
  localparam logic [10:0] NotchFarLo  = 11'(SPRITE_SIZE - 4);
  localparam logic [10:0] NotchFarHi  = 11'(SPRITE_SIZE - 1);
  localparam logic [10:0] NotchNearLo = 11'd0;
  localparam logic [10:0] NotchNearHi = 11'd3;
  localparam logic [10:0] NotchMidLo  = 11'(SPRITE_SIZE / 2 - 2);
  localparam logic [10:0] NotchMidHi  = 11'(SPRITE_SIZE / 2 + 1);

  localparam logic [3:0] DirRight = 4'b0001;
  localparam logic [3:0] DirUp    = 4'b0010;
  localparam logic [3:0] DirDown  = 4'b0100;
  localparam logic [3:0] DirLeft  = 4'b1000;

  function automatic logic sprite_hit(input logic [10:0] px, input logic [9:0] py,
                                      input logic [10:0] sx, input logic [9:0] sy);
    logic [11:0] x_end;
    logic [10:0] y_end;
    x_end = {1'b0, sx} + SizeX;
    y_end = {1'b0, sy} + SizeY;
    return (px >= sx) && (py >= sy) && ({1'b0, px} < x_end) && ({1'b0, py} < y_end);
  endfunction

  function automatic logic in_rng(input logic [10:0] v, input logic [10:0] lo,
                                  input logic [10:0] hi);
    return (v >= lo) && (v <= hi);
  endfunction

  // ---------------------------------------------------------------------------
  // Shadow registers
  // ---------------------------------------------------------------------------
  logic [4:0][10:0] pos_x_in, sx_q, sx_d;
  logic [4:0][9:0]  pos_y_in, sy_q, sy_d;
  logic [3:0]       dir_q, dir_d;
  logic             shadow_valid_q, shadow_valid_d;

  assign pos_x_in = {clyde_pos_x, inky_pos_x, pinky_pos_x, blinky_pos_x, pacman_pos_x};
  assign pos_y_in = {clyde_pos_y, inky_pos_y, pinky_pos_y, blinky_pos_y, pacman_pos_y};

  // Capture the sprite state once per frame so a frame never tears mid-draw.
  always_comb begin
    sx_d           = sx_q;
    sy_d           = sy_q;
    dir_d          = dir_q;
    shadow_valid_d = shadow_valid_q;
    if (frame_start) begin
      sx_d           = pos_x_in;
      sy_d           = pos_y_in;
      dir_d          = pacman_moving_dir;
      shadow_valid_d = 1'b1;
    end
  end

  // Shadow state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx_q           <= '0;
      sy_q           <= '0;
      dir_q          <= '0;
      shadow_valid_q <= 1'b0;
    end else begin
      sx_q           <= sx_d;
      sy_q           <= sy_d;
      dir_q          <= dir_d;
      shadow_valid_q <= shadow_valid_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Death flash
  // ---------------------------------------------------------------------------
  logic pac_visible;

`ifdef DEATH_FLASH_EN
  localparam int unsigned CntW = $clog2(DEATH_FRAMES + 1);
  localparam int unsigned PhW  = $clog2(FLASH_PERIOD + 1);

  logic [CntW-1:0] death_cnt_q, death_cnt_d;
  logic [PhW-1:0]  phase_cnt_q, phase_cnt_d, phase_inc;
  logic            flash_phase_q, flash_phase_d;

  // Advance the flash sequence once per frame; a new death only arms once the
  // previous sequence has fully expired.
  always_comb begin
    death_cnt_d   = death_cnt_q;
    phase_cnt_d   = phase_cnt_q;
    flash_phase_d = flash_phase_q;
    phase_inc     = phase_cnt_q + PhW'(1);
    if (frame_start) begin
      if (pacman_is_dead && (death_cnt_q == '0)) begin
        death_cnt_d   = CntW'(DEATH_FRAMES);
        phase_cnt_d   = '0;
        flash_phase_d = 1'b0;
      end else if (death_cnt_q != '0) begin
        death_cnt_d = death_cnt_q - CntW'(1);
        if (phase_inc == PhW'(FLASH_PERIOD)) begin
          phase_cnt_d   = '0;
          flash_phase_d = ~flash_phase_q;
        end else begin
          phase_cnt_d = phase_inc;
        end
      end
    end
  end

  // Flash counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      death_cnt_q   <= '0;
      phase_cnt_q   <= '0;
      flash_phase_q <= 1'b0;
    end else begin
      death_cnt_q   <= death_cnt_d;
      phase_cnt_q   <= phase_cnt_d;
      flash_phase_q <= flash_phase_d;
    end
  end

  assign pac_visible = !((death_cnt_q != '0) && flash_phase_q);
`else
  logic unused_dead;
  assign unused_dead = pacman_is_dead;
  assign pac_visible = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Stage 1: hit and notch detection
  // ---------------------------------------------------------------------------
  logic [4:0]  hit_raw, hit_d, hit_q;
  logic        notch_d, notch_q;
  logic        valid1_q;
  logic [10:0] lx, ly;

  // Per-sprite bounding-box test against the current shadow positions.
  always_comb begin
    hit_raw = '0;
    for (int i = 0; i < 5; i++) begin
      hit_raw[i] = sprite_hit(pixel_x, pixel_y, sx_q[i], sy_q[i]);
    end
    hit_d         = shadow_valid_q ? hit_raw : '0;
    hit_d[IdxPac] = hit_d[IdxPac] & pac_visible;
  end

  // Mouth notch in pacman-local coordinates; non-one-hot directions draw no notch.
  always_comb begin
    lx      = pixel_x - sx_q[IdxPac];
    ly      = {1'b0, pixel_y - sy_q[IdxPac]};
    notch_d = 1'b0;
    case (dir_q)
      DirRight: notch_d = in_rng(lx, NotchFarLo, NotchFarHi) &&
                          in_rng(ly, NotchMidLo, NotchMidHi);
      DirLeft:  notch_d = in_rng(lx, NotchNearLo, NotchNearHi) &&
                          in_rng(ly, NotchMidLo, NotchMidHi);
      DirUp:    notch_d = in_rng(ly, NotchNearLo, NotchNearHi) &&
                          in_rng(lx, NotchMidLo, NotchMidHi);
      DirDown:  notch_d = in_rng(ly, NotchFarLo, NotchFarHi) &&
                          in_rng(lx, NotchMidLo, NotchMidHi);
      default:  notch_d = 1'b0;
    endcase
  end

  // Stage 1 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q    <= '0;
      notch_q  <= 1'b0;
      valid1_q <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      notch_q  <= notch_d;
      valid1_q <= pixel_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: priority colour resolve
  // ---------------------------------------------------------------------------
  logic [11:0] color, rgb_d, rgb_q;
  logic        valid2_q;

  // Ghosts always draw over pacman; rgb holds when no pixel is in flight.
  always_comb begin
    if (hit_q[IdxBlinky]) begin
      color = BLINKY_COLOR;
    end else if (hit_q[IdxPinky]) begin
      color = PINKY_COLOR;
    end else if (hit_q[IdxInky]) begin
      color = INKY_COLOR;
    end else if (hit_q[IdxClyde]) begin
      color = CLYDE_COLOR;
    end else if (hit_q[IdxPac] && !notch_q) begin
      color = PACMAN_COLOR;
    end else begin
      color = BG_COLOR;
    end
    rgb_d = valid1_q ? color : rgb_q;
  end

  // Stage 2 pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q    <= '0;
      valid2_q <= 1'b0;
    end else begin
      rgb_q    <= rgb_d;
      valid2_q <= valid1_q;
    end
  end

  assign rgb       = rgb_q;
  assign rgb_valid = valid2_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed testbench for sprite_compositor; expectations are hand-computed.
// Death-flash expectations follow the DEATH_FLASH_EN build macro.
module tb_sprite_compositor;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_start;
  logic        pixel_valid;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;
  logic [10:0] pacman_pos_x, blinky_pos_x, pinky_pos_x, inky_pos_x, clyde_pos_x;
  logic [9:0]  pacman_pos_y, blinky_pos_y, pinky_pos_y, inky_pos_y, clyde_pos_y;
  logic [3:0]  pacman_moving_dir;
  logic        pacman_is_dead;
  logic [11:0] rgb;
  logic        rgb_valid;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  sprite_compositor dut (
    .clk               (clk),
    .rst               (rst),
    .frame_start       (frame_start),
    .pixel_valid       (pixel_valid),
    .pixel_x           (pixel_x),
    .pixel_y           (pixel_y),
    .pacman_pos_x      (pacman_pos_x),
    .pacman_pos_y      (pacman_pos_y),
    .blinky_pos_x      (blinky_pos_x),
    .blinky_pos_y      (blinky_pos_y),
    .pinky_pos_x       (pinky_pos_x),
    .pinky_pos_y       (pinky_pos_y),
    .inky_pos_x        (inky_pos_x),
    .inky_pos_y        (inky_pos_y),
    .clyde_pos_x       (clyde_pos_x),
    .clyde_pos_y       (clyde_pos_y),
    .pacman_moving_dir (pacman_moving_dir),
    .pacman_is_dead    (pacman_is_dead),
    .rgb               (rgb),
    .rgb_valid         (rgb_valid)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic new_frame(input logic dead);
    @(negedge clk);
    frame_start    = 1'b1;
    pacman_is_dead = dead;
    @(negedge clk);
    frame_start    = 1'b0;
    pacman_is_dead = 1'b0;
  endtask

  // One isolated pixel: rgb_valid must be low one cycle later, high two later.
  task automatic pix(input string tag, input logic fs, input logic [10:0] x,
                     input logic [9:0] y, input logic [11:0] exp);
    @(negedge clk);
    frame_start = fs;
    pixel_valid = 1'b1;
    pixel_x     = x;
    pixel_y     = y;
    @(negedge clk);
    frame_start = 1'b0;
    pixel_valid = 1'b0;
    check_val($sformatf("%s_lat1", tag), 32'(rgb_valid), 32'd0);
    @(negedge clk);
    check_val($sformatf("%s_vld", tag), 32'(rgb_valid), 32'd1);
    check_val($sformatf("%s_rgb", tag), 32'(rgb), 32'(exp));
  endtask

  logic [3:0]  dir_tab [7] = '{4'b1000, 4'b1000, 4'b0010, 4'b0100, 4'b0100, 4'b0011, 4'b0000};
  logic [10:0] x_tab   [7] = '{11'd626, 11'd637, 11'd631, 11'd631, 11'd631, 11'd637, 11'd626};
  logic [9:0]  y_tab   [7] = '{10'd40, 10'd40, 10'd33, 10'd45, 10'd33, 10'd40, 10'd40};
  logic [11:0] e_tab   [7] = '{12'h000, 12'hFF0, 12'h000, 12'h000, 12'hFF0, 12'hFF0, 12'hFF0};

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] exp;
    rst = 1'b1; frame_start = 1'b0; pixel_valid = 1'b0; pixel_x = '0; pixel_y = '0;
    pacman_is_dead = 1'b0; pacman_moving_dir = 4'b0001;
    pacman_pos_x = 11'd624;  pacman_pos_y = 10'd32;
    blinky_pos_x = 11'd1200; blinky_pos_y = 10'd700;
    pinky_pos_x  = 11'd1300; pinky_pos_y  = 10'd700;
    inky_pos_x   = 11'd1400; inky_pos_y   = 10'd700;
    clyde_pos_x  = 11'd1500; clyde_pos_y  = 10'd700;

    repeat (3) @(negedge clk);
    check_val("reset_rgb", 32'(rgb), 32'h000);
    check_val("reset_vld", 32'(rgb_valid), 32'd0);
    rst = 1'b0;

    // No frame_start yet: shadow invalid, background everywhere.
    pix("no_shadow", 1'b0, 11'd630, 10'd40, 12'h000);

    new_frame(1'b0);
    pix("pac_body", 1'b0, 11'd630, 10'd40, 12'hFF0);
    pix("pac_notch", 1'b0, 11'd637, 10'd40, 12'h000);
    pix("pac_right_edge", 1'b0, 11'd640, 10'd40, 12'h000);
    pix("pac_left_side", 1'b0, 11'd626, 10'd40, 12'hFF0);
    @(negedge clk);
    check_val("hold_vld", 32'(rgb_valid), 32'd0);
    check_val("hold_rgb", 32'(rgb), 32'hFF0);

    // Back-to-back stream, then reset mid-stream.
    @(negedge clk);
    pixel_valid = 1'b1; pixel_x = 11'd630; pixel_y = 10'd40;
    @(negedge clk);
    pixel_x = 11'd637;
    @(negedge clk);
    check_val("b2b0_vld", 32'(rgb_valid), 32'd1);
    check_val("b2b0_rgb", 32'(rgb), 32'hFF0);
    pixel_x = 11'd630;
    @(negedge clk);
    check_val("b2b1_vld", 32'(rgb_valid), 32'd1);
    check_val("b2b1_rgb", 32'(rgb), 32'h000);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_vld", 32'(rgb_valid), 32'd0);
    check_val("midrst_rgb", 32'(rgb), 32'h000);
    rst = 1'b0; pixel_valid = 1'b0;
    @(negedge clk);
    check_val("flush_vld", 32'(rgb_valid), 32'd0);
    pix("rst_shadow", 1'b0, 11'd630, 10'd40, 12'h000);

    // Notch for every direction, plus non-one-hot codes.
    for (int i = 0; i < 7; i++) begin
      pacman_moving_dir = dir_tab[i];
      new_frame(1'b0);
      pix($sformatf("dir%0d", i), 1'b0, x_tab[i], y_tab[i], e_tab[i]);
    end

    // Priority between overlapping sprites.
    pacman_moving_dir = 4'b0001;
    pacman_pos_x = 11'd96;  pacman_pos_y = 10'd96;
    blinky_pos_x = 11'd320; blinky_pos_y = 10'd400;
    clyde_pos_x  = 11'd320; clyde_pos_y  = 10'd400;
    pinky_pos_x  = 11'd0;   pinky_pos_y  = 10'd0;
    inky_pos_x   = 11'd100; inky_pos_y   = 10'd100;
    new_frame(1'b0);
    pix("blinky_over_clyde", 1'b0, 11'd325, 10'd405, 12'hF00);
    pix("pinky", 1'b0, 11'd5, 10'd5, 12'hF8C);
    pix("inky_over_pac", 1'b0, 11'd105, 10'd105, 12'h0FF);
    pix("pac_only", 1'b0, 11'd97, 10'd97, 12'hFF0);
    blinky_pos_x = 11'd1200; blinky_pos_y = 10'd700;
    new_frame(1'b0);
    pix("clyde_exposed", 1'b0, 11'd325, 10'd405, 12'hF80);

    // Mid-frame position change must not take effect until frame_start.
    clyde_pos_x = 11'd500; clyde_pos_y = 10'd300;
    pix("midframe_old", 1'b0, 11'd325, 10'd405, 12'hF80);
    pix("midframe_new", 1'b0, 11'd505, 10'd305, 12'h000);
    pix("fs_same_cycle", 1'b1, 11'd325, 10'd405, 12'hF80);
    pix("after_fs_new", 1'b0, 11'd505, 10'd305, 12'hF80);
    pix("after_fs_old", 1'b0, 11'd325, 10'd405, 12'h000);
    pix("x_last_in", 1'b0, 11'd515, 10'd305, 12'hF80);
    pix("x_first_out", 1'b0, 11'd516, 10'd305, 12'h000);

    // Sprite near maximum coordinates must not wrap.
    pinky_pos_x = 11'd1300; pinky_pos_y = 10'd700;
    inky_pos_x  = 11'd2040; inky_pos_y  = 10'd1016;
    new_frame(1'b0);
    pix("edge_hit", 1'b0, 11'd2047, 10'd1023, 12'h0FF);
    pix("edge_topleft", 1'b0, 11'd2040, 10'd1016, 12'h0FF);
    pix("nowrap_xy", 1'b0, 11'd3, 10'd3, 12'h000);
    pix("nowrap_y", 1'b0, 11'd2047, 10'd2, 12'h000);
    pix("left_of_edge", 1'b0, 11'd2039, 10'd1020, 12'h000);

    // Death flash: frame n is drawn after the n-th frame_start (the first
    // one carries the death pulse); dead is held high over frames 1..10.
    inky_pos_x = 11'd1400; inky_pos_y = 10'd700;
    pacman_pos_x = 11'd624; pacman_pos_y = 10'd32;
    new_frame(1'b1);
    for (int n = 1; n <= 125; n++) begin
`ifdef DEATH_FLASH_EN
      exp = ((n > 120) || (((n - 1) / 8) % 2 == 0)) ? 12'hFF0 : 12'h000;
`else
      exp = 12'hFF0;
`endif
      pix($sformatf("death_f%0d", n), 1'b0, 11'd630, 10'd40, exp);
      new_frame(n <= 10);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/sprite_compositor.md
Name: sprite_compositor

Overview:
- Display-side consumer of the game-logic sprite outputs: the positions of pacman and the four ghosts, the pacman direction and the death flag.
- Samples those values once per frame into shadow registers so a frame never tears mid-draw.
- For each incoming raster pixel coordinate, resolves sprite hits by priority and emits a 12-bit RGB colour through a fixed 2-stage pipeline to the VGA output stage.

Parameters:
- SPRITE_SIZE, 16, sprite edge in pixels; equals the game-logic cell ratio.
- DEATH_FRAMES, 120, number of frames pacman flashes after a death.
- FLASH_PERIOD, 8, frames per flash phase; nonzero.
- BG_COLOR, 12'h000, background colour.
- PACMAN_COLOR, 12'hFF0; BLINKY_COLOR, 12'hF00; PINKY_COLOR, 12'hF8C; INKY_COLOR, 12'h0FF; CLYDE_COLOR, 12'hF80.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- frame_start  in  1  one-cycle pulse at the start of each frame (vertical blank)
- pixel_valid  in  1  pixel_x/pixel_y are valid this cycle
- pixel_x  in  11  raster column
- pixel_y  in  10  raster row
- pacman_pos_x, blinky_pos_x, pinky_pos_x, inky_pos_x, clyde_pos_x  in  11 each  sprite top-left x
- pacman_pos_y, blinky_pos_y, pinky_pos_y, inky_pos_y, clyde_pos_y  in  10 each  sprite top-left y
- pacman_moving_dir  in  4  one-hot: RIGHT 0001, UP 0010, DOWN 0100, LEFT 1000
- pacman_is_dead  in  1  death flag from game logic
- rgb  out  12  pixel colour
- rgb_valid  out  1  rgb is valid

Behaviour:
- Reset (clk, rst high):
  - rgb=0, rgb_valid=0, pipeline flushed.
  - shadow_valid=0, death counter=0, flash_phase=0.
  - Reset mid-frame: rgb_valid is 0 the cycle after rst is sampled.
- Shadow latch: on a cycle with frame_start=1, all positions and the direction are copied into shadow registers and shadow_valid is set to 1.
  - The copied values take effect for the pixel presented in the following cycle.
  - A pixel presented in the same cycle as frame_start uses the old shadow values.
- While shadow_valid=0: every valid pixel outputs BG_COLOR.
- Hit test per sprite: local coordinates lx = pixel_x - sx, ly = pixel_y - sy. A hit requires pixel_x >= sx, pixel_y >= sy, and pixel_x < sx+SPRITE_SIZE, pixel_y < sy+SPRITE_SIZE.
  - The upper bounds are computed one bit wider (12-bit x, 11-bit y), so sprites near the maximum coordinate do not wrap.
- Pacman mouth notch (local coordinates) is transparent:
  - RIGHT: lx 12..15, ly 6..9
  - LEFT: lx 0..3, ly 6..9
  - UP: ly 0..3, lx 6..9
  - DOWN: ly 12..15, lx 6..9
  - Any direction value that is not one-hot (including 0000): no notch.
- Priority, highest first: blinky, pinky, inky, clyde, pacman (if visible and not in the notch), then BG_COLOR.
- Pipeline: stage 1 registers the hit flags and notch flag; stage 2 registers rgb. rgb_valid equals pixel_valid delayed by exactly 2 cycles.
  - Back-to-back pixels are accepted every cycle with no stall.
  - When rgb_valid=0, rgb holds its last value.
- Death flash (frame_start cycles only):
  - If pacman_is_dead=1 and counter=0: load counter=DEATH_FRAMES, flash_phase=0, phase counter=0.
  - Else if counter>0: decrement counter; increment the phase counter; when the phase counter reaches FLASH_PERIOD, clear it and toggle flash_phase.
  - Pacman is hidden when counter>0 and flash_phase=1.
  - pacman_is_dead held high while counter>0 has no effect (no retrigger until the counter expires).

Optional Feature:
- Macro DEATH_FLASH_EN.
- Defined: death counter and flash logic as above.
- Undefined: no counter or phase logic is built; pacman_is_dead is ignored and pacman is always visible.

Test Plan:
- Reset, then pixel_valid with no frame_start -> rgb_valid high 2 cycles later, rgb=12'h000; after reset asserted mid-stream, rgb_valid=0 the next cycle.
- frame_start with pacman at (624,32), dir RIGHT; pixel (630,40) -> rgb=12'hFF0; pixel (637,40) in the notch -> 12'h000; pixel (640,40) -> 12'h000.
- Blinky and clyde both at (320,400); pixel (325,405) -> 12'hF00; move blinky away, next frame -> 12'hF80.
- Positions change mid-frame without frame_start -> output still uses the old positions; after the next frame_start -> new positions.
- Sprite at x=2040, pixel_x=2047 -> hit; pixel_x=3 -> no hit (no wrap).
- DEATH_FLASH_EN defined, pacman_is_dead pulsed at frame_start -> pacman visible frames 1-8, hidden frames 9-16, repeating; visible steadily after 120 frames; undefined -> always visible.
